// File: rtl/compression_scheduler_if.sv
// Bundle of the scheduler's frame control, RAM, RNG, datapath and output stream signals.
// master = scheduler side, slave = surrounding system / bench side.
interface compression_scheduler_if #(
   parameter int GAMMA  = 13,
   parameter int ADDR_W = 10
);
   logic              start;
   logic [ADDR_W:0]   n_coeff;
   logic              busy;
   logic              done;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [GAMMA-1:0]  ram_rd_data;
   logic              rnd_valid;
   logic [GAMMA-1:0]  rnd_data;
   logic              rnd_ready;
   logic              dp_valid_in;
   logic [GAMMA-1:0]  dp_z;
   logic [GAMMA-1:0]  dp_c;
   logic              dp_valid_out;
   logic [GAMMA-1:0]  dp_z_out;
   logic              out_valid;
   logic [GAMMA-1:0]  out_data;
   logic              out_last;
   logic              out_ready;

   modport master (
      input  start, n_coeff, ram_rd_data, rnd_valid, rnd_data,
             dp_valid_out, dp_z_out, out_ready,
      output busy, done, ram_rd_en, ram_rd_addr, rnd_ready,
             dp_valid_in, dp_z, dp_c, out_valid, out_data, out_last
   );

   modport slave (
      output start, n_coeff, ram_rd_data, rnd_valid, rnd_data,
             dp_valid_out, dp_z_out, out_ready,
      input  busy, done, ram_rd_en, ram_rd_addr, rnd_ready,
             dp_valid_in, dp_z, dp_c, out_valid, out_data, out_last
   );
endinterface

// File: rtl/compression_scheduler.sv
// Streams one frame of INTT coefficients through the compression datapath into a credit-protected FIFO.
// Optional COMP_SCHED_STATS_EN adds stall_cycles / frame_cnt statistics outputs.
module compression_scheduler #(
   parameter int GAMMA      = 13,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   compression_scheduler_if.master bus
`ifdef COMP_SCHED_STATS_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [15:0] frame_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   n_lat, rd_cnt, out_cnt;
   logic [CNT_W-1:0]  inflight, fifo_count;
   logic [CNT_W:0]    credit_used;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [GAMMA-1:0]  mem [FIFO_DEPTH];
   logic [GAMMA-1:0]  c_reg, z_hold;
   logic              dp_vld_q;
   logic              start_acc, credit_ok, issue, fifo_wr, fifo_rd, ret, last_hs;

   // Every issued read reserves a FIFO slot until its result lands, so the datapath never overruns it.
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
   assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

   assign start_acc = (state == IDLE) && bus.start;
   assign issue     = (state == RUN) && bus.rnd_valid && (rd_cnt < n_lat) && credit_ok;
   assign fifo_wr   = bus.dp_valid_out && (state != IDLE);
   assign fifo_rd   = bus.out_valid && bus.out_ready;
   assign ret       = fifo_wr && (inflight != '0);
   assign last_hs   = fifo_rd && (out_cnt == n_lat - 1'b1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.n_coeff == '0) ? FIN : RUN;
         RUN:     if (rd_cnt == n_lat) state_nxt = DRAIN;
         DRAIN:   if (last_hs) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         n_lat      <= '0;
         rd_cnt     <= '0;
         out_cnt    <= '0;
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         c_reg      <= '0;
         z_hold     <= '0;
         dp_vld_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         dp_vld_q <= issue;
         if (issue)    c_reg  <= bus.rnd_data;
         if (dp_vld_q) z_hold <= bus.ram_rd_data;
         if (start_acc) begin
            n_lat   <= bus.n_coeff;
            rd_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (issue)   rd_cnt  <= rd_cnt + 1'b1;
            if (fifo_rd) out_cnt <= out_cnt + 1'b1;
         end
         if (issue && !ret)      inflight <= inflight + 1'b1;
         else if (!issue && ret) inflight <= inflight - 1'b1;
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
         if (fifo_wr && !fifo_rd)      fifo_count <= fifo_count + 1'b1;
         else if (!fifo_wr && fifo_rd) fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr] <= bus.dp_z_out;
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == FIN);
   assign bus.ram_rd_en   = issue;
   assign bus.ram_rd_addr = rd_cnt[ADDR_W-1:0];
   assign bus.rnd_ready   = issue;
   assign bus.dp_valid_in = dp_vld_q;
   // RAM word arrives the cycle after the read; pass it straight through, then hold it.
   assign bus.dp_z        = dp_vld_q ? bus.ram_rd_data : z_hold;
   assign bus.dp_c        = c_reg;
   assign bus.out_valid   = (fifo_count != '0);
   assign bus.out_data    = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.out_last    = bus.out_valid && (out_cnt == n_lat - 1'b1);

`ifdef COMP_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         frame_cnt    <= '0;
      end else begin
         if ((state == RUN) && (rd_cnt < n_lat) && !issue && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (state == FIN) frame_cnt <= frame_cnt + 1'b1;
      end
   end
`endif

endmodule
